// File: rtl/apb3_requester_synth_if.sv
// APB3 bus bundle shared by the requester and the Renode-backed completer.
interface renode_apb3_if #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
);
    logic                    pclk;
    logic                    presetn;
    logic [AddressWidth-1:0] paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic [DataWidth-1:0]    prdata;
    logic                    pready;
    logic                    pslverr;

    modport requester (
        input  pclk, presetn, prdata, pready, pslverr,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport completer (
        input  pclk, presetn, paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb3_requester_synth.sv
// APB3 requester with two pattern engines (one idle cycle between transfers, or back-to-back)
// sharing one bus; each writes an 8-word pattern, reads it back and counts mismatches/errors.

module apb3_requester_engine #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32,
    parameter bit B2B          = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    pready_i,
    input  logic [DataWidth-1:0]    prdata_i,
    input  logic                    pslverr_i,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [AddressWidth-1:0] paddr_o,
    output logic [DataWidth-1:0]    pwdata_o
);
    localparam int          PreCycles   = 2;
    localparam int          PostCycles  = 8;
    localparam int          ByteShift   = $clog2(DataWidth / 8);
    localparam logic [31:0] PatternBase = 32'h5A5A_0000;

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SETUP, S_ACCESS, S_GAP, S_POST, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 start_q;
    logic [3:0]           idx_q;
    logic [2:0]           cnt_q;
    logic                 done_q;
    logic [7:0]           error_count_q;

    logic                 launch;
    logic                 xfer_done;
    logic                 xfer_err;
    logic                 last_xfer;
    logic                 is_read;
    logic [31:0]          pattern_full;
    logic [DataWidth-1:0] pattern;

    // idx_q[3] selects the read half; idx_q[2:0] is the word index in both halves
    assign is_read      = idx_q[3];
    assign last_xfer    = (idx_q == 4'd15);
    assign pattern_full = PatternBase + {29'd0, idx_q[2:0]};
    assign pattern      = pattern_full[DataWidth-1:0];
    assign launch       = start_i && !start_q && (state_q == S_IDLE || done_q);
    assign xfer_done    = (state_q == S_ACCESS) && pready_i;
    assign xfer_err     = xfer_done && (pslverr_i || (is_read && (prdata_i != pattern)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A start edge in DONE relaunches directly: IDLE would only be a one-cycle pass-through
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (launch) state_d = S_PRE;
            S_PRE:          if (cnt_q == 3'(PreCycles - 1)) state_d = S_SETUP;
            S_SETUP:        state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready_i) begin
                    if (last_xfer) begin
                        state_d = S_POST;
                    end else if (B2B) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP:          state_d = S_SETUP;
            S_POST:         if (cnt_q == 3'(PostCycles - 1)) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        psel_o    = 1'b0;
        penable_o = 1'b0;
        pwrite_o  = 1'b0;
        paddr_o   = '0;
        pwdata_o  = '0;
        if (state_q == S_SETUP || state_q == S_ACCESS) begin
            psel_o    = 1'b1;
            penable_o = (state_q == S_ACCESS);
            pwrite_o  = !is_read;
            paddr_o   = AddressWidth'(idx_q[2:0]) << ByteShift;
            if (!is_read) begin
                pwdata_o = pattern;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            start_q       <= 1'b0;
            idx_q         <= 4'd0;
            cnt_q         <= 3'd0;
            done_q        <= 1'b0;
            error_count_q <= 8'd0;
        end else begin
            start_q <= start_i;
            cnt_q   <= (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
            done_q  <= (state_d == S_DONE);
            if (launch) begin
                idx_q         <= 4'd0;
                error_count_q <= 8'd0;
            end else begin
                if (xfer_done && !last_xfer) begin
                    idx_q <= idx_q + 4'd1;
                end
                if (xfer_err && (error_count_q != 8'hFF)) begin
                    error_count_q <= error_count_q + 8'd1;
                end
            end
        end
    end
endmodule

module apb3_requester_synth #(
    parameter int AddressWidth = 32,
    parameter int DataWidth    = 32
) (
    renode_apb3_if.requester apb3
);
    if (!(DataWidth == 8 || DataWidth == 16 || DataWidth == 32)) begin : g_bad_width
        $error("apb3_requester_synth: DataWidth must be 8, 16 or 32");
    end

    // Control variables with no driver in the design; the co-simulation bench writes them
    logic mux_select     = 1'b0;
    logic start_n_single = 1'b0;
    logic start_n_b2b    = 1'b0;

    logic [1:0]              start_vec;
    logic [1:0]              pready_vec;
    logic [1:0]              psel_vec;
    logic [1:0]              penable_vec;
    logic [1:0]              pwrite_vec;
    logic [AddressWidth-1:0] paddr_vec  [2];
    logic [DataWidth-1:0]    pwdata_vec [2];

    assign start_vec = {start_n_b2b, start_n_single};

    // Engine 0 idles between transfers, engine 1 runs back-to-back
    for (genvar gi = 0; gi < 2; gi++) begin : g_engine
        assign pready_vec[gi] = apb3.pready && (mux_select == 1'(gi));

        apb3_requester_engine #(
            .AddressWidth (AddressWidth),
            .DataWidth    (DataWidth),
            .B2B          (gi == 1)
        ) u_engine (
            .clk_i     (apb3.pclk),
            .rst_ni    (apb3.presetn),
            .start_i   (start_vec[gi]),
            .pready_i  (pready_vec[gi]),
            .prdata_i  (apb3.prdata),
            .pslverr_i (apb3.pslverr),
            .psel_o    (psel_vec[gi]),
            .penable_o (penable_vec[gi]),
            .pwrite_o  (pwrite_vec[gi]),
            .paddr_o   (paddr_vec[gi]),
            .pwdata_o  (pwdata_vec[gi])
        );
    end

    assign apb3.psel    = psel_vec[mux_select];
    assign apb3.penable = penable_vec[mux_select];
    assign apb3.pwrite  = pwrite_vec[mux_select];
    assign apb3.paddr   = paddr_vec[mux_select];
    assign apb3.pwdata  = pwdata_vec[mux_select];
endmodule

// File: tb/tb_apb3_requester_synth.sv
// Directed bench: completer model plus scoreboard of expected transfers for apb3_requester_synth.
module tb_apb3_requester_synth;
    logic        pclk = 1'b0;
    logic        presetn;
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;

    renode_apb3_if #(.AddressWidth(32), .DataWidth(32)) bus ();
    assign bus.pclk    = pclk;
    assign bus.presetn = presetn;
    assign bus.pready  = pready;
    assign bus.pslverr = pslverr;
    assign bus.prdata  = prdata;

    apb3_requester_synth #(.AddressWidth(32), .DataWidth(32)) dut (.apb3(bus));

    always #5 pclk = ~pclk;

    wire       done_single = dut.g_engine[0].u_engine.done_q;
    wire       done_b2b    = dut.g_engine[1].u_engine.done_q;
    wire [7:0] err_single  = dut.g_engine[0].u_engine.error_count_q;
    wire [7:0] err_b2b     = dut.g_engine[1].u_engine.error_count_q;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } xfer_t;

    xfer_t       sb[$];
    int          completions[$];
    logic [31:0] mem [8];
    int compared = 0, mismatched = 0;
    int cycle = 0, xfer_idx = 0, access_cnt = 0, wait_access = 0;
    int low_cnt = 0, psel_hi_cnt = 0;
    int wait_idx = -1, wait_len = 0, corrupt_idx = -1, slverr_idx = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic begin_run();
        sb.delete();
        completions.delete();
        xfer_idx    = 0;
        low_cnt     = 0;
        wait_access = 0;
        for (int i = 0; i < 16; i++) begin
            xfer_t t;
            t.addr = 32'((i % 8) * 4);
            t.wr   = (i < 8);
            t.data = 32'h5A5A_0000 + 32'(i % 8);
            sb.push_back(t);
        end
    endtask

    task automatic launch(input bit b2b);
        @(negedge pclk);
        if (b2b) dut.start_n_b2b = 1'b0; else dut.start_n_single = 1'b0;
        @(negedge pclk);
        if (b2b) dut.start_n_b2b = 1'b1; else dut.start_n_single = 1'b1;
        repeat (2) @(negedge pclk);
    endtask

    function automatic int bad_gaps(input int spacing);
        int n = 0;
        for (int i = 1; i < completions.size(); i++)
            if (completions[i] - completions[i-1] != spacing) n++;
        return n;
    endfunction

    task automatic finish_run(input bit b2b, input int spacing, input int exp_low, input int exp_err);
        int n = 0;
        while (!(b2b ? done_b2b : done_single) && n < 340) begin
            @(negedge pclk);
            n++;
        end
        if (b2b) begin
            check("done_b2b", done_b2b, 1);
            check("err_b2b", err_b2b, exp_err);
        end else begin
            check("done_single", done_single, 1);
            check("err_single", err_single, exp_err);
        end
        check("sb_drained", sb.size(), 0);
        check("xfer_count", completions.size(), 16);
        check("idle_between", low_cnt, exp_low);
        if (spacing > 0) check("xfer_spacing", bad_gaps(spacing), 0);
        $display("run %s done: %0d transfers, errors %0d", b2b ? "b2b" : "single",
                 completions.size(), b2b ? err_b2b : err_single);
    endtask

    // Completer model and transfer monitor, evaluated away from the active edge
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 32'h0;
        forever begin
            @(negedge pclk);
            cycle++;
            if (!presetn) begin
                pready  = 1'b1;
                pslverr = 1'b0;
            end else begin
                if (bus.psel) psel_hi_cnt++;
                if (bus.psel && !bus.penable) access_cnt = 0;
                if (bus.psel && bus.penable) begin
                    access_cnt++;
                    check("sb_nonempty", sb.size() != 0, 1'b1);
                    if (sb.size() != 0) begin
                        check("paddr", bus.paddr, sb[0].addr);
                        check("pwrite", bus.pwrite, sb[0].wr);
                        if (sb[0].wr) check("pwdata", bus.pwdata, sb[0].data);
                        pready  = !(xfer_idx == wait_idx && access_cnt <= wait_len);
                        pslverr = 1'b0;
                        if (pready) begin
                            if (bus.pwrite) begin
                                mem[bus.paddr[4:2]] = bus.pwdata;
                            end else begin
                                prdata  = (xfer_idx == corrupt_idx) ? 32'h0 : mem[bus.paddr[4:2]];
                                pslverr = (xfer_idx == slverr_idx);
                            end
                            if (xfer_idx == wait_idx) wait_access = access_cnt;
                            $display("xfer %0d %s addr=0x%0h data=0x%0h cycle=%0d", xfer_idx,
                                     bus.pwrite ? "WR" : "RD", bus.paddr,
                                     bus.pwrite ? bus.pwdata : prdata, cycle);
                            completions.push_back(cycle);
                            void'(sb.pop_front());
                            xfer_idx++;
                        end
                    end
                end else begin
                    pready  = 1'b1;
                    pslverr = 1'b0;
                end
                if (!bus.psel && xfer_idx >= 1 && xfer_idx <= 15) low_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        presetn = 1'b0;
        pready  = 1'b1;
        pslverr = 1'b0;
        prdata  = 32'h0;

        // Reset state
        repeat (3) @(negedge pclk);
        check("rst_psel", bus.psel, 0);
        check("rst_penable", bus.penable, 0);
        check("rst_pwrite", bus.pwrite, 0);
        check("rst_paddr", bus.paddr, 0);
        check("rst_pwdata", bus.pwdata, 0);
        check("rst_done_single", done_single, 0);
        check("rst_err_b2b", err_b2b, 0);
        presetn = 1'b1;
        psel_hi_cnt = 0;
        repeat (5) @(negedge pclk);
        check("idle_after_reset", psel_hi_cnt, 0);

        // Single engine: first SETUP two PRE cycles after the sampled start edge
        begin_run();
        dut.start_n_single = 1'b1;
        @(negedge pclk);
        check("pre1_psel", bus.psel, 0);
        @(negedge pclk);
        check("pre2_psel", bus.psel, 0);
        @(negedge pclk);
        check("setup_psel", bus.psel, 1);
        check("setup_penable", bus.penable, 0);
        check("setup_pwrite", bus.pwrite, 1);
        check("setup_paddr", bus.paddr, 32'h0);
        check("setup_pwdata", bus.pwdata, 32'h5A5A_0000);
        finish_run(1'b0, 3, 15, 0);

        // Holding start high must not relaunch
        psel_hi_cnt = 0;
        repeat (30) @(negedge pclk);
        check("hold_no_relaunch", psel_hi_cnt, 0);
        check("hold_done", done_single, 1);

        // Relaunch by 0 -> 1
        begin_run();
        launch(1'b0);
        finish_run(1'b0, 3, 15, 0);

        // Back-to-back engine on the bus
        @(negedge pclk);
        dut.mux_select = 1'b1;
        begin_run();
        launch(1'b1);
        finish_run(1'b1, 2, 0, 0);
        check("single_untouched", done_single, 1);

        // Unselected engine stalls; bus stays idle
        @(negedge pclk);
        dut.mux_select = 1'b0;
        psel_hi_cnt = 0;
        launch(1'b1);
        repeat (30) @(negedge pclk);
        check("unsel_bus_idle", psel_hi_cnt, 0);
        check("unsel_b2b_done", done_b2b, 0);

        // Wait states on write 4, zero data on read 2, pslverr on read 5
        wait_idx    = 4;
        wait_len    = 3;
        corrupt_idx = 10;
        slverr_idx  = 13;
        begin_run();
        launch(1'b0);
        finish_run(1'b0, 0, 15, 2);
        check("wait_access_cycles", wait_access, 4);
        wait_idx    = -1;
        corrupt_idx = -1;
        slverr_idx  = -1;

        // Asynchronous reset in the middle of a transfer
        begin_run();
        launch(1'b0);
        n = 0;
        while (!(bus.psel && bus.penable) && n < 30) begin
            @(negedge pclk);
            n++;
        end
        check("mid_access_seen", bus.psel && bus.penable, 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        check("async_rst_psel", bus.psel, 0);
        check("async_rst_penable", bus.penable, 0);
        check("async_rst_paddr", bus.paddr, 0);
        dut.start_n_single = 1'b0;
        dut.start_n_b2b    = 1'b0;
        sb.delete();
        @(negedge pclk);
        check("async_rst_done_single", done_single, 0);
        check("async_rst_err_single", err_single, 0);
        check("async_rst_done_b2b", done_b2b, 0);
        presetn = 1'b1;
        psel_hi_cnt = 0;
        repeat (10) @(negedge pclk);
        check("idle_after_async_rst", psel_hi_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
